// File: rtl/alu_pc_dmem_pkg.sv
// Shared ALU opcodes, flag bit positions and default datapath width for alu_pc_dmem_unit.
// No logic lives here; latency and backpressure do not apply.
package alu_pc_dmem_pkg;

   localparam int DATA_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ORR = 2'b11
   } alu_op_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_pc_dmem_if.sv
// Bus bundle between a driver (master) and alu_pc_dmem_unit (slave).
// Results are combinational except pc_out; there is no handshake and no backpressure.
interface alu_pc_dmem_if
   import alu_pc_dmem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
);
   logic [DATA_W-1:0] pc_in;
   logic [DATA_W-1:0] pc_out;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [1:0]        alu_ctrl;
   logic [DATA_W-1:0] alu_result;
   logic [3:0]        alu_flags;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output pc_in, alu_a, alu_b, alu_ctrl, mem_we,
      input  pc_out, alu_result, alu_flags, mem_rdata
   );

   modport slave (
      input  pc_in, alu_a, alu_b, alu_ctrl, mem_we,
      output pc_out, alu_result, alu_flags, mem_rdata
   );
endinterface

// File: rtl/alu_pc_dmem_unit_dmem_array.sv
// 2**DATA_W x DATA_W data memory: synchronous write, combinational read, no write-through bypass.
// Optional DMEM_CLEAR_ON_RESET_EN clears every word while rst_n is low; writes are blocked in reset.
module dmem_array #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [DATA_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   localparam int DEPTH = 2 ** DATA_W;

   logic [DATA_W-1:0] mem [DEPTH];

`ifdef DMEM_CLEAR_ON_RESET_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[addr] <= wdata;
      end
   end
`else
   // Contents survive reset; rst_n only gates the write strobe.
   always_ff @(posedge clk) begin
      if (rst_n && we) begin
         mem[addr] <= wdata;
      end
   end
`endif

   assign rdata = mem[addr];

endmodule

// File: rtl/alu_pc_dmem_unit.sv
// Combinational ALU driving a data-memory address, plus a free-running PC register (1-cycle load).
// ALU result, flags and read data are zero-latency; no stall or backpressure exists.
module alu_pc_dmem_unit
   import alu_pc_dmem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_pc_dmem_if.slave  bus
);
   logic [DATA_W-1:0] pc_q;
   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] res;
   logic              carry;
   logic              ovf;
   logic [3:0]        flags;
   alu_op_t           op;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= '0;
      end else begin
         pc_q <= bus.pc_in;
      end
   end

   assign op   = alu_op_t'(bus.alu_ctrl);
   assign sum  = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
   assign diff = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};

   // For SUB the carry is the inverted borrow, i.e. set when a >= b unsigned.
   always_comb begin
      res   = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      case (op)
         ALU_ADD: begin
            res   = sum[DATA_W-1:0];
            carry = sum[DATA_W];
            ovf   = (bus.alu_a[DATA_W-1] == bus.alu_b[DATA_W-1]) &&
                    (sum[DATA_W-1] != bus.alu_a[DATA_W-1]);
         end
         ALU_SUB: begin
            res   = diff[DATA_W-1:0];
            carry = ~diff[DATA_W];
            ovf   = (bus.alu_a[DATA_W-1] != bus.alu_b[DATA_W-1]) &&
                    (diff[DATA_W-1] != bus.alu_a[DATA_W-1]);
         end
         ALU_AND: res = bus.alu_a & bus.alu_b;
         ALU_ORR: res = bus.alu_a | bus.alu_b;
         default: res = '0;
      endcase
   end

   always_comb begin
      flags         = '0;
      flags[FLAG_N] = res[DATA_W-1];
      flags[FLAG_Z] = (res == '0);
      flags[FLAG_C] = carry;
      flags[FLAG_V] = ovf;
   end

   dmem_array #(.DATA_W(DATA_W)) u_dmem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bus.mem_we),
      .addr  (res),
      .wdata (bus.alu_b),
      .rdata (bus.mem_rdata)
   );

   assign bus.pc_out     = pc_q;
   assign bus.alu_result = res;
   assign bus.alu_flags  = flags;

endmodule

// File: tb/tb_alu_pc_dmem_unit.sv
// Directed-vector bench for alu_pc_dmem_unit; builds with or without DMEM_CLEAR_ON_RESET_EN.
module tb_alu_pc_dmem_unit;
   import alu_pc_dmem_pkg::*;

   logic clk;
   logic rst_n;
   int   vec_cnt;
   int   err_cnt;

   alu_pc_dmem_if #(.DATA_W(8)) bus ();

   alu_pc_dmem_unit #(.DATA_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_alu(input logic [1:0] ctrl, input logic [7:0] a, input logic [7:0] b);
      bus.alu_ctrl = ctrl;
      bus.alu_a    = a;
      bus.alu_b    = b;
      #1;
   endtask

   task automatic test_reset();
      rst_n       = 1'b1;
      bus.pc_in   = 8'h33;
      bus.mem_we  = 1'b0;
      bus.alu_a   = 8'h00;
      bus.alu_b   = 8'h00;
      bus.alu_ctrl = 2'b00;
      step();
      vec_cnt++;
      if (bus.pc_out !== 8'h33) begin
         err_cnt++;
         $display("FAIL pc_load got=%h exp=%h", bus.pc_out, 8'h33);
      end
      #2 rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (bus.pc_out !== 8'h00) begin
         err_cnt++;
         $display("FAIL pc_async_reset got=%h exp=%h", bus.pc_out, 8'h00);
      end
      bus.pc_in = 8'h05;
      step();
      vec_cnt++;
      if (bus.pc_out !== 8'h00) begin
         err_cnt++;
         $display("FAIL pc_held_in_reset got=%h exp=%h", bus.pc_out, 8'h00);
      end
      #3 rst_n = 1'b1;
      step();
      vec_cnt++;
      if (bus.pc_out !== 8'h05) begin
         err_cnt++;
         $display("FAIL pc_after_release got=%h exp=%h", bus.pc_out, 8'h05);
      end
      bus.pc_in = 8'hA7;
      step();
      vec_cnt++;
      if (bus.pc_out !== 8'hA7) begin
         err_cnt++;
         $display("FAIL pc_follow got=%h exp=%h", bus.pc_out, 8'hA7);
      end
   endtask

   task automatic test_add();
      drive_alu(2'b00, 8'h7F, 8'h01);
      vec_cnt++;
      if (bus.alu_result !== 8'h80 || bus.alu_flags !== 4'b1001) begin
         err_cnt++;
         $display("FAIL add_7f_01 got=%h/%b exp=80/1001", bus.alu_result, bus.alu_flags);
      end
      drive_alu(2'b00, 8'hFF, 8'h01);
      vec_cnt++;
      if (bus.alu_result !== 8'h00 || bus.alu_flags !== 4'b0110) begin
         err_cnt++;
         $display("FAIL add_ff_01 got=%h/%b exp=00/0110", bus.alu_result, bus.alu_flags);
      end
      drive_alu(2'b00, 8'h80, 8'h80);
      vec_cnt++;
      if (bus.alu_result !== 8'h00 || bus.alu_flags !== 4'b0111) begin
         err_cnt++;
         $display("FAIL add_80_80 got=%h/%b exp=00/0111", bus.alu_result, bus.alu_flags);
      end
   endtask

   task automatic test_sub();
      drive_alu(2'b01, 8'h05, 8'h05);
      vec_cnt++;
      if (bus.alu_result !== 8'h00 || bus.alu_flags !== 4'b0110) begin
         err_cnt++;
         $display("FAIL sub_05_05 got=%h/%b exp=00/0110", bus.alu_result, bus.alu_flags);
      end
      drive_alu(2'b01, 8'h00, 8'h01);
      vec_cnt++;
      if (bus.alu_result !== 8'hFF || bus.alu_flags !== 4'b1000) begin
         err_cnt++;
         $display("FAIL sub_00_01 got=%h/%b exp=FF/1000", bus.alu_result, bus.alu_flags);
      end
      drive_alu(2'b01, 8'h80, 8'h01);
      vec_cnt++;
      if (bus.alu_result !== 8'h7F || bus.alu_flags !== 4'b0011) begin
         err_cnt++;
         $display("FAIL sub_80_01 got=%h/%b exp=7F/0011", bus.alu_result, bus.alu_flags);
      end
   endtask

   task automatic test_logic();
      drive_alu(2'b10, 8'hF0, 8'h0F);
      vec_cnt++;
      if (bus.alu_result !== 8'h00 || bus.alu_flags !== 4'b0100) begin
         err_cnt++;
         $display("FAIL and_f0_0f got=%h/%b exp=00/0100", bus.alu_result, bus.alu_flags);
      end
      drive_alu(2'b11, 8'hF0, 8'h0F);
      vec_cnt++;
      if (bus.alu_result !== 8'hFF || bus.alu_flags !== 4'b1000) begin
         err_cnt++;
         $display("FAIL orr_f0_0f got=%h/%b exp=FF/1000", bus.alu_result, bus.alu_flags);
      end
      drive_alu(2'b10, 8'hFF, 8'hFF);
      vec_cnt++;
      if (bus.alu_result !== 8'hFF || bus.alu_flags !== 4'b1000) begin
         err_cnt++;
         $display("FAIL and_ff_ff got=%h/%b exp=FF/1000", bus.alu_result, bus.alu_flags);
      end
   endtask

   task automatic test_mem();
      // Seed addr 30 with 10 so the pre-edge read has a known old value.
      drive_alu(2'b00, 8'h20, 8'h10);
      bus.mem_we = 1'b1;
      step();
      bus.mem_we = 1'b0;
      drive_alu(2'b00, 8'h10, 8'h20);
      vec_cnt++;
      if (bus.mem_rdata !== 8'h10) begin
         err_cnt++;
         $display("FAIL mem_seed got=%h exp=%h", bus.mem_rdata, 8'h10);
      end
      bus.mem_we = 1'b1;
      #1;
      vec_cnt++;
      if (bus.mem_rdata !== 8'h10) begin
         err_cnt++;
         $display("FAIL mem_old_before_edge got=%h exp=%h", bus.mem_rdata, 8'h10);
      end
      step();
      vec_cnt++;
      if (bus.mem_rdata !== 8'h20) begin
         err_cnt++;
         $display("FAIL mem_new_after_edge got=%h exp=%h", bus.mem_rdata, 8'h20);
      end
      bus.mem_we = 1'b0;
      drive_alu(2'b00, 8'h00, 8'h31);
      bus.mem_we = 1'b1;
      step();
      bus.mem_we = 1'b0;
      vec_cnt++;
      if (bus.mem_rdata !== 8'h31) begin
         err_cnt++;
         $display("FAIL mem_addr31 got=%h exp=%h", bus.mem_rdata, 8'h31);
      end
      drive_alu(2'b00, 8'h10, 8'h20);
      for (int i = 0; i < 3; i++) begin
         step();
         vec_cnt++;
         if (bus.mem_rdata !== 8'h20) begin
            err_cnt++;
            $display("FAIL mem_retain cycle=%0d got=%h exp=%h", i, bus.mem_rdata, 8'h20);
         end
      end
   endtask

   task automatic test_blocked_write();
      logic [7:0] exp_dat;
`ifdef DMEM_CLEAR_ON_RESET_EN
      exp_dat = 8'h00;
`else
      exp_dat = 8'h20;
`endif
      drive_alu(2'b00, 8'h20, 8'h10);
      rst_n      = 1'b0;
      bus.mem_we = 1'b1;
      step();
      step();
      bus.mem_we = 1'b0;
      #2 rst_n = 1'b1;
      #1;
      vec_cnt++;
      if (bus.mem_rdata !== exp_dat) begin
         err_cnt++;
         $display("FAIL mem_blocked_in_reset got=%h exp=%h", bus.mem_rdata, exp_dat);
      end
   endtask

`ifdef DMEM_CLEAR_ON_RESET_EN
   task automatic test_clear();
      drive_alu(2'b01, 8'hDA, 8'hAA);
      bus.mem_we = 1'b1;
      step();
      bus.mem_we = 1'b0;
      vec_cnt++;
      if (bus.alu_result !== 8'h30 || bus.mem_rdata !== 8'hAA) begin
         err_cnt++;
         $display("FAIL clear_setup got=%h/%h exp=30/AA", bus.alu_result, bus.mem_rdata);
      end
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      #1;
      vec_cnt++;
      if (bus.mem_rdata !== 8'h00) begin
         err_cnt++;
         $display("FAIL clear_on_reset got=%h exp=%h", bus.mem_rdata, 8'h00);
      end
   endtask
`endif

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_mem();
      test_blocked_write();
`ifdef DMEM_CLEAR_ON_RESET_EN
      test_clear();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
      $fatal(1, "timeout");
   end

endmodule
